cache_port_arbiter: RTL
=======================

Name: cache_port_arbiter

Overview:
- Shares the single cache core-side port between two requesters: port 0 (data/load-store) and port 1 (fetch/debug).
- Each requester uses the same pulse/fin protocol as the cache: single-cycle rd_en/wr_en, then wait for rd_fin/wr_fin.
- The block buffers one request per requester, grants round-robin, issues exactly one cache transaction at a time and routes completion back.
- It sits between the core-side masters and the cache top.

Parameters:
ADDR_W, 27, address width ({13 tag, 10 index, 4 offset})
DATA_W, 32, data width
TIMEOUT_CYCLES, 0, max cycles in WAIT before forced completion; 0 disables the timeout
TO_W, 16, width of the timeout counter

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
r0_rd_en / r0_wr_en  in  1 each  port-0 request pulses
r0_rd_addr / r0_wr_addr  in  ADDR_W each  port-0 addresses
r0_wr_data  in  DATA_W  port-0 write data
r0_rd_fin / r0_wr_fin  out  1 each  port-0 completion pulses
r0_rd_data  out  DATA_W  port-0 read data
r1_*  (same set as r0_*)  port-1 equivalents
core2cache_rd_en / core2cache_wr_en  out  1 each  cache request pulses
core2cache_rd_addr / core2cache_wr_addr  out  ADDR_W each  cache addresses
core2cache_wr_data  out  DATA_W  cache write data
cache2core_rd_fin / cache2core_wr_fin  in  1 each  cache completion
cache2core_rd_data  in  DATA_W  cache read data
busy  out  1  high in ISSUE or WAIT
grant_id  out  1  port owning the current or last transaction
err_overrun  out  2  sticky per-port protocol violation
err_timeout  out  1  sticky timeout flag

Behaviour:
- All outputs are registered. Reset values: every output 0; pending slots empty; last_grant = 1 (port 0 wins the first tie); state IDLE; timeout counter 0.
- Capture:
  - A port's rd_en or wr_en high in cycle c sets that port's pending slot at the c edge: type, address and wr_data are latched.
  - If rd_en and wr_en are both high, the write is captured, the read is dropped, and err_overrun[port] is set.
- Overrun:
  - A request from a port whose slot is pending or in flight is dropped; err_overrun[port] is set.
  - The existing slot is unchanged.
  - The flag stays set until reset.
- States:
  - IDLE: if any slot is pending, select one (single pending → that port; both → the port != last_grant). Update last_grant and grant_id, go to ISSUE.
  - ISSUE: for one cycle, drive core2cache_{rd|wr}_en = 1 with the selected address/data on the matching address bus and wr_data. Go to WAIT.
  - WAIT: the en outputs are 0. Addresses and wr_data hold until the next ISSUE.
    - On cache2core fin matching the issued type: register the fin pulse (1 cycle) to the granted port; on a read, also register rd_data. Clear that port's slot and go to IDLE.
    - A fin of the non-matching type is ignored.
- Latency:
  - Request pulse in cycle c → pending in c+1 → IDLE selects → cache en high in cycle c+2 when the arbiter is idle and uncontended.
  - Cache fin in cycle f → requester fin in f+1.
  - The next cache en is no earlier than f+2.
- Requester rd_data holds its last value between reads. The other port's fin outputs stay 0.
- A fin while in IDLE or ISSUE is ignored.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments each WAIT cycle and resets on leaving WAIT.
  - When it reaches TIMEOUT_CYCLES with no matching fin: return the fin to the granted port (rd_data = 0 for reads), set err_timeout, clear the slot, go to IDLE.
  - A late cache fin arriving afterwards is ignored.
- A new request from the other port during WAIT is captured normally. A port may re-request in the cycle its fin is seen; it is captured.
- Reset mid-operation: all slots are dropped, state goes to IDLE, no fin is emitted, and subsequent stray cache fins are ignored.

Test Plan:
- Single write: port-0 wr pulse, addr 0x0000010, data 0x0000ffff, cache fin 3 cycles after en → core2cache_wr_en high exactly 2 cycles after the request, correct addr/data, r0_wr_fin 1 cycle after cache fin, grant_id = 0.
- Simultaneous reads: port-0 read 0x0000040 and port-1 read 0x000004C in the same cycle, cache returns 0x1111 then 0x2222 → port 0 served first and gets 0x1111; port 1 gets 0x2222; next tie grants port 0 again (alternation).
- Overrun: port-1 issues a second read while its first is in WAIT → second request dropped, err_overrun = 2'b10, only one cache transaction for port 1.
- Mismatched fin: read outstanding, cache pulses wr_fin → ignored, still WAIT; later rd_fin with 0xaaaa completes normally.
- Timeout: TIMEOUT_CYCLES = 8, cache never responds → r0_rd_fin after 8 WAIT cycles with rd_data 0, err_timeout = 1; a stray rd_fin afterwards produces no output.
- Reset in WAIT: assert rstn low for one cycle mid-transaction, then cache fin → all outputs 0, no requester fin, next request is served normally.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Two-requester front end for the cache core port.
// Buffers one request per port, grants round-robin, one transaction at a time.
module cache_port_arbiter #(
  parameter int ADDR_W         = 27,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_W           = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              r0_rd_en,
  input  logic              r0_wr_en,
  input  logic [ADDR_W-1:0] r0_rd_addr,
  input  logic [ADDR_W-1:0] r0_wr_addr,
  input  logic [DATA_W-1:0] r0_wr_data,
  output logic              r0_rd_fin,
  output logic              r0_wr_fin,
  output logic [DATA_W-1:0] r0_rd_data,
  input  logic              r1_rd_en,
  input  logic              r1_wr_en,
  input  logic [ADDR_W-1:0] r1_rd_addr,
  input  logic [ADDR_W-1:0] r1_wr_addr,
  input  logic [DATA_W-1:0] r1_wr_data,
  output logic              r1_rd_fin,
  output logic              r1_wr_fin,
  output logic [DATA_W-1:0] r1_rd_data,
  output logic              core2cache_rd_en,
  output logic              core2cache_wr_en,
  output logic [ADDR_W-1:0] core2cache_rd_addr,
  output logic [ADDR_W-1:0] core2cache_wr_addr,
  output logic [DATA_W-1:0] core2cache_wr_data,
  input  logic              cache2core_rd_fin,
  input  logic              cache2core_wr_fin,
  input  logic [DATA_W-1:0] cache2core_rd_data,
  output logic              busy,
  output logic              grant_id,
  output logic [1:0]        err_overrun,
  output logic              err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam int TO_LIM = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_W-1:0] TO_LIM_V = TO_W'(TO_LIM);

  logic [1:0]              state;
  logic                    last_grant;
  logic [TO_W-1:0]         to_cnt;

  logic [1:0]              req_rd;
  logic [1:0]              req_wr;
  logic [1:0]              req_any;
  logic [1:0][ADDR_W-1:0]  req_addr;
  logic [1:0][DATA_W-1:0]  req_data;

  logic [1:0]              slot_vld;
  logic [1:0]              slot_wr;
  logic [1:0][ADDR_W-1:0]  slot_addr;
  logic [1:0][DATA_W-1:0]  slot_data;

  logic                    sel;
  logic                    fin_hit;
  logic                    to_hit;
  logic                    done;

  assign req_rd      = {r1_rd_en, r0_rd_en};
  assign req_wr      = {r1_wr_en, r0_wr_en};
  assign req_any     = req_rd | req_wr;
  assign req_addr[0] = r0_wr_en ? r0_wr_addr : r0_rd_addr;
  assign req_addr[1] = r1_wr_en ? r1_wr_addr : r1_rd_addr;
  assign req_data[0] = r0_wr_data;
  assign req_data[1] = r1_wr_data;

  // Tie goes to the port that did not win last time.
  assign sel = (slot_vld[0] & slot_vld[1]) ? ~last_grant : slot_vld[1];

  assign fin_hit = slot_wr[grant_id] ? cache2core_wr_fin
                                     : cache2core_rd_fin;
  assign to_hit  = TO_EN && (to_cnt == TO_LIM_V);
  assign done    = (state == S_WAIT) && (fin_hit || to_hit);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state              <= S_IDLE;
      last_grant         <= 1'b1;
      to_cnt             <= '0;
      slot_vld           <= '0;
      slot_wr            <= '0;
      slot_addr          <= '0;
      slot_data          <= '0;
      r0_rd_fin          <= 1'b0;
      r0_wr_fin          <= 1'b0;
      r0_rd_data         <= '0;
      r1_rd_fin          <= 1'b0;
      r1_wr_fin          <= 1'b0;
      r1_rd_data         <= '0;
      core2cache_rd_en   <= 1'b0;
      core2cache_wr_en   <= 1'b0;
      core2cache_rd_addr <= '0;
      core2cache_wr_addr <= '0;
      core2cache_wr_data <= '0;
      busy               <= 1'b0;
      grant_id           <= 1'b0;
      err_overrun        <= '0;
      err_timeout        <= 1'b0;
    end else begin
      r0_rd_fin <= 1'b0;
      r0_wr_fin <= 1'b0;
      r1_rd_fin <= 1'b0;
      r1_wr_fin <= 1'b0;

      for (int p = 0; p < 2; p++) begin
        if (done && (grant_id == 1'(p)))
          slot_vld[p] <= 1'b0;
        if (req_any[p]) begin
          if (slot_vld[p]) begin
            err_overrun[p] <= 1'b1;
          end else begin
            slot_vld[p]  <= 1'b1;
            slot_wr[p]   <= req_wr[p];
            slot_addr[p] <= req_addr[p];
            if (req_wr[p])
              slot_data[p] <= req_data[p];
            if (req_wr[p] && req_rd[p])
              err_overrun[p] <= 1'b1;
          end
        end
      end

      // Timed-out reads return zero data.
      if (done) begin
        if (!fin_hit)
          err_timeout <= 1'b1;
        if (grant_id) begin
          if (slot_wr[1]) begin
            r1_wr_fin <= 1'b1;
          end else begin
            r1_rd_fin  <= 1'b1;
            r1_rd_data <= fin_hit ? cache2core_rd_data : '0;
          end
        end else begin
          if (slot_wr[0]) begin
            r0_wr_fin <= 1'b1;
          end else begin
            r0_rd_fin  <= 1'b1;
            r0_rd_data <= fin_hit ? cache2core_rd_data : '0;
          end
        end
      end

      unique case (state)
        S_IDLE: begin
          if (|slot_vld) begin
            grant_id   <= sel;
            last_grant <= sel;
            busy       <= 1'b1;
            state      <= S_ISSUE;
            if (slot_wr[sel]) begin
              core2cache_wr_en   <= 1'b1;
              core2cache_wr_addr <= slot_addr[sel];
              core2cache_wr_data <= slot_data[sel];
            end else begin
              core2cache_rd_en   <= 1'b1;
              core2cache_rd_addr <= slot_addr[sel];
            end
          end
        end
        S_ISSUE: begin
          core2cache_rd_en <= 1'b0;
          core2cache_wr_en <= 1'b0;
          to_cnt           <= '0;
          state            <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            to_cnt <= '0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
